// File: rtl/axis_fmcw_framer_if.sv
// AXI4-Stream bundle used for both the DDC input side and the FFT output side
// of axis_fmcw_framer.
interface axis_fmcw_framer_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_fmcw_framer.sv
// FMCW frame builder: per ramp, skip settling samples, pass len samples, zero-pad to 2^n beats.
// Optional macro FMCW_FRAMER_TUSER_EN: carry the frame sequence number on m_axis.tuser.
module axis_fmcw_framer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 12,
    parameter int SN_WIDTH         = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 ramp,
    input  logic [4:0]           cfg_log2n,
    input  logic [7:0]           cfg_skip,
    input  logic [CNT_WIDTH:0]   cfg_len,
    input  logic                 err_clr,
    axis_fmcw_framer_if.slave    s_axis,
    axis_fmcw_framer_if.master   m_axis,
    output logic [SN_WIDTH-1:0]  sts_seqno,
    output logic                 err_short,
    output logic                 err_overflow
);
    localparam int CW = CNT_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_SKIP, S_DATA, S_PAD, S_HOLD} state_t;

    state_t                      state_q;
    logic                        sync1_q, sync2_q, sync3_q;
    logic                        pend_q, started_q;
    logic [7:0]                  skip_q, skip_cnt_q;
    logic [CW-1:0]               len_q, last_q, beat_q;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic                        tvalid_q, tlast_q;
    logic [SN_WIDTH-1:0]         seqno_q;
    logic                        err_short_q, err_overflow_q;

    logic                        rise, out_free, xfer_last;
    logic                        load_data, load_pad, load;
    logic                        overflow_ev, short_ev, start;
    logic [4:0]                  log2n_d;
    logic [CW-1:0]               n_beats_d, len_d;
    logic [SN_WIDTH-1:0]         seqno_d;
    state_t                      start_state_d, fill_state;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        log2n_d = cfg_log2n;
        if (cfg_log2n < 5'd3)                 log2n_d = 5'd3;
        else if (cfg_log2n > 5'(CNT_WIDTH))   log2n_d = 5'(CNT_WIDTH);
        n_beats_d = CW'(1) << log2n_d;
        len_d     = (cfg_len > n_beats_d) ? n_beats_d : cfg_len;
        seqno_d   = started_q ? seqno_q + SN_WIDTH'(1) : seqno_q;

        rise        = sync2_q & ~sync3_q;
        out_free    = ~tvalid_q | m_axis.tready;
        xfer_last   = tvalid_q & tlast_q & m_axis.tready;
        load_data   = (state_q == S_DATA) & s_axis.tvalid & out_free;
        overflow_ev = (state_q == S_DATA) & s_axis.tvalid & ~out_free;
        load_pad    = (state_q == S_PAD) & out_free & (beat_q <= last_q);
        load        = load_data | load_pad;

        // A ramp landing on the very beat that completes the frame is a clean restart, not a collision.
        short_ev = rise & ~pend_q & ((state_q == S_SKIP) | (state_q == S_DATA) |
                                     ((state_q == S_PAD) & ~xfer_last));
        start    = (rise & ((state_q == S_IDLE) | (state_q == S_HOLD))) |
                   ((state_q == S_PAD) & xfer_last & (pend_q | rise));

        fill_state    = (len_q != '0) ? S_DATA : S_PAD;
        start_state_d = (cfg_skip != 8'd0) ? S_SKIP : ((len_d != '0) ? S_DATA : S_PAD);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            pend_q         <= 1'b0;
            started_q      <= 1'b0;
            skip_q         <= '0;
            skip_cnt_q     <= '0;
            len_q          <= '0;
            last_q         <= '0;
            beat_q         <= '0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            seqno_q        <= '0;
            err_short_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            sync1_q <= ramp;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;

            err_short_q    <= (err_short_q & ~err_clr) | short_ev;
            err_overflow_q <= (err_overflow_q & ~err_clr) | overflow_ev;

            if (load) begin
                tdata_q  <= load_data ? s_axis.tdata : '0;
                tvalid_q <= 1'b1;
                tlast_q  <= (beat_q == last_q);
                beat_q   <= beat_q + CW'(1);
            end else if (m_axis.tready) begin
                tvalid_q <= 1'b0;
            end

            case (state_q)
                S_SKIP: if (s_axis.tvalid) begin
                    skip_cnt_q <= skip_cnt_q + 8'd1;
                    if (skip_cnt_q == skip_q - 8'd1) state_q <= fill_state;
                end
                S_DATA: if (load_data && (beat_q + CW'(1) == len_q)) state_q <= S_PAD;
                S_PAD:  if (xfer_last) state_q <= S_HOLD;
                default: ;
            endcase

            // Collision: finish the current frame with zeros, then restart immediately.
            if (short_ev) begin
                pend_q  <= 1'b1;
                state_q <= S_PAD;
            end

            if (start) begin
                state_q    <= start_state_d;
                skip_q     <= cfg_skip;
                len_q      <= len_d;
                last_q     <= n_beats_d - CW'(1);
                beat_q     <= '0;
                skip_cnt_q <= '0;
                pend_q     <= 1'b0;
                seqno_q    <= seqno_d;
                started_q  <= 1'b1;
            end
        end
    end

`ifdef FMCW_FRAMER_TUSER_EN
    logic [SN_WIDTH-1:0] tuser_q;

    always_ff @(posedge aclk) begin
        if (!aresetn)  tuser_q <= '0;
        else if (load) tuser_q <= seqno_q;
    end

    assign m_axis.tuser = tuser_q;
`else
    assign m_axis.tuser = '0;
`endif

    assign s_axis.tready = 1'b1;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign sts_seqno     = seqno_q;
    assign err_short     = err_short_q;
    assign err_overflow  = err_overflow_q;
endmodule
